// File: rtl/rf_seq_pkg.sv
// rtl/rf_seq_pkg.sv - shared types and widths for the register-file op sequencer
package rf_seq_pkg;

    localparam int FIFO_DEPTH = 2;
    localparam int REG_AW     = 5;
    localparam int FUNCT_W    = 4;
    localparam int DATA_W     = 32;
    localparam int CNT_W      = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WB
    } seq_state_t;

    typedef struct packed {
        logic [REG_AW-1:0]  rs1;
        logic [REG_AW-1:0]  rs2;
        logic [REG_AW-1:0]  rd;
        logic [REG_AW-1:0]  shamt;
        logic [FUNCT_W-1:0] funct;
        logic               wen;
    } seq_cmd_t;

endpackage

// File: rtl/rf_seq_fifo.sv
// rtl/rf_seq_fifo.sv - two-entry command queue with push/pop/count
module rf_seq_fifo
    import rf_seq_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  seq_cmd_t push_data,
    input  logic     pop,
    output seq_cmd_t pop_data,
    output logic [1:0] count
);

    seq_cmd_t mem [FIFO_DEPTH];
    logic     wr_ptr;
    logic     rd_ptr;

    assign pop_data = mem[rd_ptr];

    // Payload storage carries no reset; occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rf_op_sequencer.sv
// rtl/rf_op_sequencer.sv - sequences queued ALU ops through RF read/write-back; RF_SEQ_R0_GUARD_EN blocks writes to r0
module rf_op_sequencer
    import rf_seq_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [REG_AW-1:0]   cmd_rs1,
    input  logic [REG_AW-1:0]   cmd_rs2,
    input  logic [REG_AW-1:0]   cmd_rd,
    input  logic [REG_AW-1:0]   cmd_shamt,
    input  logic [FUNCT_W-1:0]  cmd_funct,
    input  logic                cmd_wen,
    output logic [REG_AW-1:0]   rd_addr1,
    output logic [REG_AW-1:0]   rd_addr2,
    output logic [REG_AW-1:0]   wr_addr,
    output logic [REG_AW-1:0]   shamt,
    output logic [FUNCT_W-1:0]  funct,
    output logic                RegWrite,
    input  logic [DATA_W-1:0]   wr_data,
    output logic                done_valid,
    output logic [REG_AW-1:0]   done_rd,
    output logic [DATA_W-1:0]   done_result,
    output logic [CNT_W-1:0]    op_count
);

    seq_state_t state;
    seq_cmd_t   cmd_in;
    seq_cmd_t   head;
    logic [1:0] fifo_count;
    logic       push;
    logic       pop;
    logic       cur_wen;
    logic       wb_en;

    assign cmd_in = '{rs1: cmd_rs1, rs2: cmd_rs2, rd: cmd_rd,
                      shamt: cmd_shamt, funct: cmd_funct, wen: cmd_wen};

    assign cmd_ready = (fifo_count < 2'(FIFO_DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (fifo_count != 2'd0) && ((state == IDLE) || (state == WB));

    rf_seq_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (cmd_in),
        .pop       (pop),
        .pop_data  (head),
        .count     (fifo_count)
    );

`ifdef RF_SEQ_R0_GUARD_EN
    assign wb_en = cur_wen && (wr_addr != '0);
`else
    assign wb_en = cur_wen;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cur_wen     <= 1'b0;
            rd_addr1    <= '0;
            rd_addr2    <= '0;
            wr_addr     <= '0;
            shamt       <= '0;
            funct       <= '0;
            RegWrite    <= 1'b0;
            done_valid  <= 1'b0;
            done_rd     <= '0;
            done_result <= '0;
            op_count    <= '0;
        end else begin
            done_valid <= 1'b0;
            // The datapath drives are loaded only on pop, so they hold while idle.
            if (pop) begin
                cur_wen  <= head.wen;
                rd_addr1 <= head.rs1;
                rd_addr2 <= head.rs2;
                wr_addr  <= head.rd;
                shamt    <= head.shamt;
                funct    <= head.funct;
            end
            case (state)
                IDLE: begin
                    RegWrite <= 1'b0;
                    if (pop) begin
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    RegWrite <= wb_en;
                    state    <= WB;
                end
                WB: begin
                    RegWrite    <= 1'b0;
                    done_valid  <= 1'b1;
                    done_rd     <= wr_addr;
                    done_result <= wr_data;
                    op_count    <= op_count + 1'b1;
                    state       <= pop ? ISSUE : IDLE;
                end
                default: begin
                    RegWrite <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
